// File: rtl/imem_fetch.sv
// imem_fetch: instruction memory with a valid/ready fetch port, a program-load
// write port and a post-reset fill sequencer.
//
// After reset the block walks every word and writes FILL_WORD (INIT), then
// serves fetches (RUN). Each accepted fetch produces one registered response
// the following cycle; misaligned or out-of-range addresses return FILL_WORD
// with the matching fault bits instead of memory contents.
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   req_valid/req_ready     fetch handshake, req_addr = byte address
//   resp_valid/resp_ready   response handshake, resp_inst/resp_fault payload
//                           resp_fault[0] misaligned, resp_fault[1] out of range
//   flush                   drop the pending response, block acceptance
//   ld_we/ld_addr/ld_data   program-load write (RUN only, bits [1:0] ignored)
//   init_done               fill finished, block in RUN
//
// state | meaning
// INIT  | writing FILL_WORD to word[fill_cnt], fetches and loads blocked
// RUN   | serving fetches and load writes

module imem_fetch #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH      = 1024,
    parameter logic [DATA_WIDTH-1:0] FILL_WORD  = 32'h00000013
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_inst,
    output logic [1:0]            resp_fault,
    input  logic                  flush,
    input  logic                  ld_we,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_data,
    output logic                  init_done
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [IDX_W-1:0]      fill_cnt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [IDX_W-1:0] req_idx;
    logic [IDX_W-1:0] ld_idx;
    logic             req_misaligned;
    logic             req_oor;
    logic             ld_oor;
    logic             accept;
    logic             unused_ld_lsb;

    assign req_idx        = req_addr[IDX_W+1:2];
    assign ld_idx         = ld_addr[IDX_W+1:2];
    // Any address bit above the word index means the access is past the array.
    assign req_oor        = (req_addr >> (IDX_W + 2)) != '0;
    assign ld_oor         = (ld_addr >> (IDX_W + 2)) != '0;
    assign req_misaligned = req_addr[1:0] != 2'b00;
    assign unused_ld_lsb  = ^ld_addr[1:0];

    assign accept = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_INIT;
            fill_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_INIT) begin
                fill_cnt <= fill_cnt + 1'b1;
            end else begin
                fill_cnt <= '0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        init_done = 1'b0;
        req_ready = 1'b0;
        case (state)
            S_INIT: begin
                if (fill_cnt == IDX_W'(DEPTH - 1)) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                init_done = 1'b1;
                req_ready = !flush && (!resp_valid || resp_ready);
            end
            default: state_nxt = S_INIT;
        endcase
    end

    // Single write port shared by the fill sequencer and program load.
    // Writes are suppressed while reset is held so a mid-run reset cannot
    // land a stray load.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == S_INIT) begin
                mem[fill_cnt] <= FILL_WORD;
            end else if (ld_we && !ld_oor) begin
                mem[ld_idx] <= ld_data;
            end
        end
    end

    // The read of mem here sees the pre-edge contents, giving read-first
    // behaviour when a load and a fetch hit the same word on one edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp_valid <= 1'b0;
            resp_inst  <= '0;
            resp_fault <= 2'b00;
        end else if (accept) begin
            resp_valid <= 1'b1;
            if (req_misaligned || req_oor) begin
                resp_inst  <= FILL_WORD;
                resp_fault <= {req_oor, req_misaligned};
            end else begin
                resp_inst  <= mem[req_idx];
                resp_fault <= 2'b00;
            end
        end else if (flush || resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

endmodule

// File: doc/imem_fetch.md
# imem_fetch

Parametrised synchronous instruction memory with a valid/ready fetch port, a program-load write port and a post-reset fill sequencer. Sits between the IF-stage PC logic and the decoder: the PC issues word-aligned byte addresses, the block returns one instruction per accepted request with one cycle of latency and flags misaligned or out-of-range fetches instead of returning garbage.

## Interface
- DATA_WIDTH, 32, instruction word width in bits
- ADDR_WIDTH, 32, byte-address width of req_addr and ld_addr
- DEPTH, 1024, number of words; power of two, at least 4
- FILL_WORD, 32'h00000013, value written to every word during INIT and returned on faults
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  fetch request present
- req_ready  out  1  request accepted on this edge if req_valid is also high
- req_addr  in  ADDR_WIDTH  byte address of the instruction
- resp_valid  out  1  resp_inst/resp_fault hold a response
- resp_ready  in  1  consumer takes the response on this edge
- resp_inst  out  DATA_WIDTH  fetched instruction
- resp_fault  out  2  bit0 misaligned (req_addr[1:0] != 0), bit1 out of range (word index >= DEPTH)
- flush  in  1  discard the pending response (branch redirect)
- ld_we  in  1  program-load write strobe
- ld_addr  in  ADDR_WIDTH  byte address of load write; bits [1:0] ignored
- ld_data  in  DATA_WIDTH  load write data
- init_done  out  1  fill finished, block in RUN

## Operation
- Word index = req_addr[clog2(DEPTH)+1:2]; out of range when any req_addr bit above clog2(DEPTH)+1 is set.
- FSM states: INIT, RUN. Reset enters INIT with fill counter = 0.
- INIT: each cycle writes FILL_WORD to word[counter], counter increments; after writing word DEPTH-1, next state RUN. req_ready = 0; ld_we ignored (write dropped).
- RUN: init_done = 1. req_ready = !flush && (!resp_valid || resp_ready), combinational.
- Accepted request: response register loads mem[index] and fault = 0, or FILL_WORD and the fault bits when either fault applies; resp_valid set.
- resp_valid && resp_ready && no new accept: resp_valid cleared. Accept and drain on the same edge: new response replaces old, resp_valid stays 1.
- Backpressure: while resp_valid && !resp_ready, resp_inst/resp_fault hold stable.
- flush: resp_valid cleared on that edge; req_ready forced 0 so no request is accepted that cycle.
- Load write in RUN: mem[ld word index] <= ld_data; out-of-range ld_addr dropped silently.
- Same-edge load write and fetch of the same word: read-first, response carries the old word; the new word is visible from the next request onward.

## Timing
- Reset values: req_ready 0, resp_valid 0, resp_inst 0, resp_fault 0, init_done 0, FSM INIT, fill counter 0.
- INIT lasts exactly DEPTH cycles after the first edge with rst_n = 1; init_done rises after that edge.
- Fetch latency: request accepted at edge N, response valid after edge N (visible cycle N+1).
- Throughput: one fetch per cycle with resp_ready held high.
- Reset asserted mid-operation (INIT or RUN): on that edge return to INIT, drop the pending response, restart fill from word 0; memory contents are overwritten by the fill.

## Test plan
- DEPTH=16: release reset -> init_done = 0 for 16 cycles, then 1; fetch 0x8 -> resp_inst 0x00000013, resp_fault 0.
- Load 0x4 <= 0xDEADBEEF, 0x8 <= 0x12345678; fetch 0x4, 0x8 back-to-back with resp_ready = 1 -> responses on consecutive cycles, correct data, req_ready stays 1.
- Fetch 0x4, hold resp_ready = 0 for 3 cycles -> req_ready = 0, resp_inst stable 0xDEADBEEF; raise resp_ready with new req 0x8 -> 0x12345678 next cycle.
- Fetch 0x6 -> resp_fault = 2'b01, resp_inst = FILL_WORD; fetch 0x40 (DEPTH=16) -> resp_fault = 2'b10.
- Same edge: ld_we to 0x4 with 0xCAFEF00D and fetch 0x4 -> response 0xDEADBEEF; next fetch 0x4 -> 0xCAFEF00D. Flush while resp_valid -> resp_valid 0 next cycle, no accept.
- Assert rst_n = 0 at INIT cycle 7 and in RUN with a pending response -> resp_valid 0, init_done 0, full 16-cycle fill again, fetch 0x4 returns FILL_WORD.
